// File: rtl/pacer_pkg.sv
// Shared encodings for the dual-chamber pace scheduler: FSM states, pacing modes
// and interval register selects.
package pacer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VRP     = 3'd1,
    VA_WAIT = 3'd2,
    A_PACE  = 3'd3,
    AV_WAIT = 3'd4,
    V_PACE  = 3'd5
  } pace_state_e;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_VVI = 2'b01;
  localparam logic [1:0] MODE_DDD = 2'b10;

  localparam logic [1:0] SEL_VAI = 2'd0;
  localparam logic [1:0] SEL_AVI = 2'd1;
  localparam logic [1:0] SEL_REF = 2'd2;
  localparam logic [1:0] SEL_PW  = 2'd3;

  // The reserved code 11 behaves exactly like OFF.
  function automatic logic mode_active(input logic [1:0] m);
    return (m == MODE_VVI) || (m == MODE_DDD);
  endfunction

endpackage

// File: rtl/pace_interval_timer.sv
// Loadable down counter that times every interval of the pace scheduler.
// It holds at zero until the next load.
module pace_interval_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dual_chamber_pace_scheduler.sv
// Dual-chamber pace scheduler: sequences atrial/ventricular pace pulses from
// sensed events with programmable VA, AV, refractory and pulse-width intervals.
//
// state   | meaning
// IDLE    | pacing off, outputs low
// VRP     | ventricular refractory, senses ignored, mode latched on exit
// VA_WAIT | waiting for a sense or VA expiry
// A_PACE  | atrial pace pulse (pa=1)
// AV_WAIT | waiting for ventricular sense or AV expiry
// V_PACE  | ventricular pace pulse (pv=1)
module dual_chamber_pace_scheduler
  import pacer_pkg::*;
#(
  parameter int TW      = 8,
  parameter int CW      = 8,
  parameter int VAI_DEF = 20,
  parameter int AVI_DEF = 6,
  parameter int REF_DEF = 8,
  parameter int PW_DEF  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic          sa,
  input  logic          sv,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_sel,
  input  logic [TW-1:0] cfg_data,
  output logic          pa,
  output logic          pv,
  output logic [2:0]    state_o,
  output logic [CW-1:0] a_pace_cnt,
  output logic [CW-1:0] v_pace_cnt
);

  pace_state_e   state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [TW-1:0] vai_q, vai_d, avi_q, avi_d, ref_q, ref_d, pw_q, pw_d;
  logic [TW-1:0] wr_val, ivl, load_val;
  logic [CW-1:0] a_cnt_q, a_cnt_d, v_cnt_q, v_cnt_d;
  logic          pa_q, pv_q, load, zero;

  pace_interval_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  // A zero interval would never expire cleanly, so it is stored as 1.
  always_comb begin
    wr_val = (cfg_data == '0) ? TW'(1) : cfg_data;
    vai_d  = vai_q;
    avi_d  = avi_q;
    ref_d  = ref_q;
    pw_d   = pw_q;
    if (cfg_we) begin
      case (cfg_sel)
        SEL_VAI: vai_d = wr_val;
        SEL_AVI: avi_d = wr_val;
        SEL_REF: ref_d = wr_val;
        SEL_PW:  pw_d  = wr_val;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (!mode_active(mode)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = VRP;
        VRP:     if (zero) begin
                   state_d = VA_WAIT;
                   mode_d  = mode;
                 end
        VA_WAIT: if (sv)                            state_d = VRP;
                 else if (sa && mode_q == MODE_DDD) state_d = AV_WAIT;
                 else if (zero) state_d = (mode_q == MODE_DDD) ? A_PACE : V_PACE;
        A_PACE:  if (zero) state_d = AV_WAIT;
        AV_WAIT: if (sv)        state_d = VRP;
                 else if (zero) state_d = V_PACE;
        V_PACE:  if (zero) state_d = VRP;
        default: state_d = IDLE;
      endcase
    end

    // Every transition into a timed state reloads the timer with N-1.
    case (state_d)
      VRP:            ivl = ref_q;
      VA_WAIT:        ivl = vai_q;
      AV_WAIT:        ivl = avi_q;
      A_PACE, V_PACE: ivl = pw_q;
      default:        ivl = TW'(1);
    endcase
    load     = (state_d != state_q) && (state_d != IDLE);
    load_val = ivl - TW'(1);

    a_cnt_d = a_cnt_q;
    v_cnt_d = v_cnt_q;
    if (state_d == A_PACE && state_q != A_PACE && a_cnt_q != '1) a_cnt_d = a_cnt_q + CW'(1);
    if (state_d == V_PACE && state_q != V_PACE && v_cnt_q != '1) v_cnt_d = v_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_OFF;
      vai_q   <= TW'(VAI_DEF);
      avi_q   <= TW'(AVI_DEF);
      ref_q   <= TW'(REF_DEF);
      pw_q    <= TW'(PW_DEF);
      a_cnt_q <= '0;
      v_cnt_q <= '0;
      pa_q    <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      vai_q   <= vai_d;
      avi_q   <= avi_d;
      ref_q   <= ref_d;
      pw_q    <= pw_d;
      a_cnt_q <= a_cnt_d;
      v_cnt_q <= v_cnt_d;
      pa_q    <= (state_d == A_PACE);
      pv_q    <= (state_d == V_PACE);
    end
  end

  assign pa         = pa_q;
  assign pv         = pv_q;
  assign state_o    = state_q;
  assign a_pace_cnt = a_cnt_q;
  assign v_pace_cnt = v_cnt_q;

endmodule

// File: tb/tb_dual_chamber_pace_scheduler.sv
// Directed bench for the pace scheduler: a segment table of {inputs, cycles,
// expected state/outputs/counters} plus hand-written config, OFF and reset cases.
module tb_dual_chamber_pace_scheduler;
  import pacer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = MODE_OFF;
  logic       sa = 1'b0, sv = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic [7:0] cfg_data = 8'd0;
  logic       pa, pv;
  logic [2:0] state_o;
  logic [7:0] a_pace_cnt, v_pace_cnt;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic [1:0] mode;
    logic       sa;
    logic       sv;
    logic       tog;
    int         n;
    logic [2:0] st;
    logic       pa;
    logic       pv;
    int         a;
    int         v;
  } seg_t;

  seg_t tbl[22];

  dual_chamber_pace_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .sa         (sa),
    .sv         (sv),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .pa         (pa),
    .pv         (pv),
    .state_o    (state_o),
    .a_pace_cnt (a_pace_cnt),
    .v_pace_cnt (v_pace_cnt)
  );

  always #5 clk = ~clk;

  function automatic seg_t mk(input logic [1:0] m, input logic a_in, input logic v_in,
                              input logic tg, input int n, input logic [2:0] st,
                              input logic p_a, input logic p_v, input int a, input int v);
    seg_t s;
    s.mode = m; s.sa = a_in; s.sv = v_in; s.tog = tg; s.n = n;
    s.st = st; s.pa = p_a; s.pv = p_v; s.a = a; s.v = v;
    return s;
  endfunction

  function automatic logic [31:0] obs();
    return {11'b0, state_o, pa, pv, a_pace_cnt, v_pace_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs for each step are driven #1 after an edge and take effect at the next edge.
  task automatic run_seg(input seg_t s, input string tag);
    logic [31:0] exp;
    exp = {11'b0, s.st, s.pa, s.pv, 8'(s.a), 8'(s.v)};
    for (int i = 0; i < s.n; i++) begin
      mode = s.mode;
      sa   = s.tog ? ~sa : s.sa;
      sv   = s.sv;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      check($sformatf("%s[%0d]", tag, i), obs(), exp);
    end
  endtask

  task automatic do_cfg(input logic [1:0] sel, input logic [7:0] data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_data = data;
  endtask

  initial begin
    // Default DDD period, sa-triggered AV, sv in AV, senses ignored in VRP, sv at VA expiry.
    tbl[0]  = mk(MODE_DDD, 0, 0, 0,  8, VRP,     0, 0, 0, 0);
    tbl[1]  = mk(MODE_DDD, 0, 0, 0, 20, VA_WAIT, 0, 0, 0, 0);
    tbl[2]  = mk(MODE_DDD, 0, 0, 0,  2, A_PACE,  1, 0, 1, 0);
    tbl[3]  = mk(MODE_DDD, 0, 0, 0,  6, AV_WAIT, 0, 0, 1, 0);
    tbl[4]  = mk(MODE_DDD, 0, 0, 0,  2, V_PACE,  0, 1, 1, 1);
    tbl[5]  = mk(MODE_DDD, 0, 0, 0,  8, VRP,     0, 0, 1, 1);
    tbl[6]  = mk(MODE_DDD, 0, 0, 0,  5, VA_WAIT, 0, 0, 1, 1);
    tbl[7]  = mk(MODE_DDD, 1, 0, 0,  1, AV_WAIT, 0, 0, 1, 1);
    tbl[8]  = mk(MODE_DDD, 0, 0, 0,  5, AV_WAIT, 0, 0, 1, 1);
    tbl[9]  = mk(MODE_DDD, 0, 0, 0,  2, V_PACE,  0, 1, 1, 2);
    tbl[10] = mk(MODE_DDD, 0, 0, 0,  8, VRP,     0, 0, 1, 2);
    tbl[11] = mk(MODE_DDD, 0, 0, 0, 20, VA_WAIT, 0, 0, 1, 2);
    tbl[12] = mk(MODE_DDD, 0, 0, 0,  2, A_PACE,  1, 0, 2, 2);
    tbl[13] = mk(MODE_DDD, 0, 0, 0,  3, AV_WAIT, 0, 0, 2, 2);
    tbl[14] = mk(MODE_DDD, 0, 1, 0,  1, VRP,     0, 0, 2, 2);
    tbl[15] = mk(MODE_DDD, 0, 1, 0,  1, VRP,     0, 0, 2, 2);
    tbl[16] = mk(MODE_DDD, 1, 0, 0,  1, VRP,     0, 0, 2, 2);
    tbl[17] = mk(MODE_DDD, 0, 0, 0,  5, VRP,     0, 0, 2, 2);
    tbl[18] = mk(MODE_DDD, 0, 0, 0, 20, VA_WAIT, 0, 0, 2, 2);
    tbl[19] = mk(MODE_DDD, 0, 1, 0,  1, VRP,     0, 0, 2, 2);
    tbl[20] = mk(MODE_DDD, 0, 0, 0,  7, VRP,     0, 0, 2, 2);
    tbl[21] = mk(MODE_DDD, 0, 0, 0, 10, VA_WAIT, 0, 0, 2, 2);

    mode = MODE_DDD;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", obs(), {11'b0, 3'(IDLE), 1'b0, 1'b0, 8'd0, 8'd0});
    rst = 1'b0;
    check("after_release", obs(), {11'b0, 3'(IDLE), 1'b0, 1'b0, 8'd0, 8'd0});

    for (int k = 0; k < 22; k++) run_seg(tbl[k], $sformatf("tbl%0d", k));

    // VAI written mid VA_WAIT applies to the next interval; PW=0 gives a 1-cycle pulse.
    do_cfg(SEL_VAI, 8'd5);
    run_seg(mk(MODE_DDD, 0, 0, 0, 1, VA_WAIT, 0, 0, 2, 2), "vai_wr");
    do_cfg(SEL_PW, 8'd0);
    run_seg(mk(MODE_DDD, 0, 0, 0, 9, VA_WAIT, 0, 0, 2, 2), "va_old");
    run_seg(mk(MODE_DDD, 0, 0, 0, 1, A_PACE,  1, 0, 3, 2), "pw1_a");
    run_seg(mk(MODE_DDD, 0, 0, 0, 6, AV_WAIT, 0, 0, 3, 2), "av_a");
    run_seg(mk(MODE_DDD, 0, 0, 0, 1, V_PACE,  0, 1, 3, 3), "pw1_v");
    run_seg(mk(MODE_DDD, 0, 0, 0, 8, VRP,     0, 0, 3, 3), "vrp_b");
    run_seg(mk(MODE_DDD, 0, 0, 0, 5, VA_WAIT, 0, 0, 3, 3), "va_new");
    run_seg(mk(MODE_DDD, 0, 0, 0, 1, A_PACE,  1, 0, 4, 3), "pw1_a2");
    run_seg(mk(MODE_DDD, 0, 0, 0, 6, AV_WAIT, 0, 0, 4, 3), "av_b");
    run_seg(mk(MODE_DDD, 0, 0, 0, 1, V_PACE,  0, 1, 4, 4), "pw1_v2");

    // VVI with sa toggling every cycle: only ventricular paces, 30-cycle period.
    do_cfg(SEL_PW, 8'd2);
    run_seg(mk(MODE_VVI, 0, 0, 1,  1, VRP,     0, 0, 4, 4), "vvi_vrp0");
    do_cfg(SEL_VAI, 8'd20);
    run_seg(mk(MODE_VVI, 0, 0, 1,  7, VRP,     0, 0, 4, 4), "vvi_vrp1");
    run_seg(mk(MODE_VVI, 0, 0, 1, 20, VA_WAIT, 0, 0, 4, 4), "vvi_va1");
    run_seg(mk(MODE_VVI, 0, 0, 1,  2, V_PACE,  0, 1, 4, 5), "vvi_v1");
    run_seg(mk(MODE_VVI, 0, 0, 1,  8, VRP,     0, 0, 4, 5), "vvi_vrp2");
    run_seg(mk(MODE_VVI, 0, 0, 1, 20, VA_WAIT, 0, 0, 4, 5), "vvi_va2");
    run_seg(mk(MODE_VVI, 0, 0, 1,  2, V_PACE,  0, 1, 4, 6), "vvi_v2");

    // OFF during the first A_PACE cycle truncates the pulse; reserved mode acts as OFF.
    run_seg(mk(MODE_DDD, 0, 0, 0,  8, VRP,     0, 0, 4, 6), "ddd_vrp");
    run_seg(mk(MODE_DDD, 0, 0, 0, 20, VA_WAIT, 0, 0, 4, 6), "ddd_va");
    run_seg(mk(MODE_DDD, 0, 0, 0,  1, A_PACE,  1, 0, 5, 6), "ddd_a");
    run_seg(mk(MODE_OFF, 0, 0, 0,  1, IDLE,    0, 0, 5, 6), "off_cut");
    run_seg(mk(MODE_OFF, 0, 0, 0,  2, IDLE,    0, 0, 5, 6), "off_hold");
    run_seg(mk(MODE_DDD, 0, 0, 0,  1, VRP,     0, 0, 5, 6), "rsv_vrp");
    run_seg(mk(2'b11,    0, 0, 0,  1, IDLE,    0, 0, 5, 6), "rsv_off");

    // Async reset in the middle of V_PACE with a pending REF change.
    run_seg(mk(MODE_DDD, 0, 0, 0,  8, VRP,     0, 0, 5, 6), "pre_vrp");
    run_seg(mk(MODE_DDD, 0, 0, 0, 20, VA_WAIT, 0, 0, 5, 6), "pre_va");
    run_seg(mk(MODE_DDD, 0, 0, 0,  2, A_PACE,  1, 0, 6, 6), "pre_a");
    do_cfg(SEL_REF, 8'd3);
    run_seg(mk(MODE_DDD, 0, 0, 0,  1, AV_WAIT, 0, 0, 6, 6), "pre_av0");
    run_seg(mk(MODE_DDD, 0, 0, 0,  5, AV_WAIT, 0, 0, 6, 6), "pre_av1");
    run_seg(mk(MODE_DDD, 0, 0, 0,  1, V_PACE,  0, 1, 6, 7), "pre_v");
    rst = 1'b1;
    #1;
    check("rst_async", obs(), {11'b0, 3'(IDLE), 1'b0, 1'b0, 8'd0, 8'd0});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_seg(mk(MODE_DDD, 0, 0, 0,  8, VRP,     0, 0, 0, 0), "post_vrp");
    run_seg(mk(MODE_DDD, 0, 0, 0, 20, VA_WAIT, 0, 0, 0, 0), "post_va");
    run_seg(mk(MODE_DDD, 0, 0, 0,  2, A_PACE,  1, 0, 1, 0), "post_a");
    run_seg(mk(MODE_DDD, 0, 0, 0,  6, AV_WAIT, 0, 0, 1, 0), "post_av");
    run_seg(mk(MODE_DDD, 0, 0, 0,  2, V_PACE,  0, 1, 1, 1), "post_v");

    // All intervals written as 0 (stored as 1): 5-cycle DDD period, then saturate.
    run_seg(mk(MODE_OFF, 0, 0, 0, 1, IDLE, 0, 0, 1, 1), "sat_idle");
    do_cfg(SEL_REF, 8'd0);
    run_seg(mk(MODE_OFF, 0, 0, 0, 1, IDLE, 0, 0, 1, 1), "wr_ref");
    do_cfg(SEL_VAI, 8'd0);
    run_seg(mk(MODE_OFF, 0, 0, 0, 1, IDLE, 0, 0, 1, 1), "wr_vai");
    do_cfg(SEL_AVI, 8'd0);
    run_seg(mk(MODE_OFF, 0, 0, 0, 1, IDLE, 0, 0, 1, 1), "wr_avi");
    do_cfg(SEL_PW, 8'd0);
    run_seg(mk(MODE_OFF, 0, 0, 0, 1, IDLE, 0, 0, 1, 1), "wr_pw");
    run_seg(mk(MODE_DDD, 0, 0, 0, 1, VRP,     0, 0, 1, 1), "min_vrp");
    run_seg(mk(MODE_DDD, 0, 0, 0, 1, VA_WAIT, 0, 0, 1, 1), "min_va");
    run_seg(mk(MODE_DDD, 0, 0, 0, 1, A_PACE,  1, 0, 2, 1), "min_a");
    run_seg(mk(MODE_DDD, 0, 0, 0, 1, AV_WAIT, 0, 0, 2, 1), "min_av");
    run_seg(mk(MODE_DDD, 0, 0, 0, 1, V_PACE,  0, 1, 2, 2), "min_v");
    run_seg(mk(MODE_DDD, 0, 0, 0, 1, VRP,     0, 0, 2, 2), "min_vrp2");
    mode = MODE_DDD;
    sa = 1'b0;
    sv = 1'b0;
    repeat (1500) @(posedge clk);
    #1;
    check("a_sat", {24'b0, a_pace_cnt}, 32'd255);
    check("v_sat", {24'b0, v_pace_cnt}, 32'd255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
